// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between N_REQ producers, the arbiter and the FIFO write side.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16
);
  logic [N_REQ-1:0]        req_vld;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_en_mask;
  logic [N_REQ-1:0]        req_rdy;
  logic                    wr;
  logic [DATA_W-1:0]       wr_data;
  logic                    full;

  // arbiter side
  modport master (
    input  req_vld, req_data, req_en_mask, full,
    output req_rdy, wr, wr_data
  );

  // producer / FIFO side
  modport slave (
    output req_vld, req_data, req_en_mask, full,
    input  req_rdy, wr, wr_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with bounded burst ownership.
// Grants are combinational (zero-latency accept); an owner that drops out
// mid-burst is released in the same cycle so the next requester wins with
// no bubble.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16,
  localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int BC_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                clk,
  input  logic                rst,
  fifo_wr_arbiter_if.master   bus,
  output logic [IDX_W-1:0]    owner,
  output logic                busy,
  output logic [CNT_W-1:0]    xfer_cnt
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] rr_ptr, rr_n, owner_n, base, sel;
  logic [BC_W-1:0]  burst_cnt, bcnt_n;
  logic [N_REQ-1:0] elig, grant;
  logic             found;

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_REQ - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  assign elig = bus.req_vld & bus.req_en_mask;
  // A released owner hands priority to the next index, same as a completed burst.
  assign base = (state == BURST) ? inc_idx(owner) : rr_ptr;

  // First eligible requester scanning base, base+1, ... modulo N_REQ
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = int'(base) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && elig[j]) begin
        found = 1'b1;
        sel   = IDX_W'(j);
      end
    end
  end

  // Next-state, ownership and grant decision
  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    owner_n = owner;
    bcnt_n  = burst_cnt;
    grant   = '0;
    if (state == BURST && elig[owner]) begin
      // owner keeps the port; full only stalls, ownership is held
      if (!bus.full) begin
        grant[owner] = 1'b1;
        bcnt_n       = burst_cnt + BC_W'(1);
        if (bcnt_n == BC_W'(MAX_BURST)) begin
          state_n = IDLE;
          rr_n    = inc_idx(owner);
        end
      end
    end else begin
      if (state == BURST) begin
        state_n = IDLE;
        rr_n    = inc_idx(owner);
      end
      if (found && !bus.full) begin
        grant[sel] = 1'b1;
        owner_n    = sel;
        bcnt_n     = BC_W'(1);
        if (MAX_BURST == 1) rr_n = inc_idx(sel);
        else                state_n = BURST;
      end
    end
    if (rst) grant = '0;
  end

  // Write data mux driven by the one-hot grant
  always_comb begin
    bus.wr_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) bus.wr_data = bus.req_data[i*DATA_W +: DATA_W];
  end

  assign bus.req_rdy = grant;
  assign bus.wr      = |grant;
  assign busy        = (state == BURST);

  // State registers and accepted-word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      xfer_cnt  <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_n;
      owner     <= owner_n;
      burst_cnt <= bcnt_n;
      if (bus.wr) xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: randomized data/traffic against a behavioural
// round-robin/burst model, plus directed scenarios with fixed grant tables.
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_REQ(4), .DATA_W(16)) a0 ();
  fifo_wr_arbiter_if #(.N_REQ(4), .DATA_W(16)) b1 ();

  logic [1:0]  owner0, owner1;
  logic        busy0, busy1;
  logic [15:0] xfer0;
  logic [3:0]  xfer1;

  fifo_wr_arbiter #(.N_REQ(4), .DATA_W(16), .MAX_BURST(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(a0), .owner(owner0), .busy(busy0), .xfer_cnt(xfer0));

  fifo_wr_arbiter #(.N_REQ(4), .DATA_W(16), .MAX_BURST(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .owner(owner1), .busy(busy1), .xfer_cnt(xfer1));

  wire [39:0] act0 = {a0.req_rdy, a0.wr, a0.wr_data, owner0, busy0, xfer0};
  wire [27:0] act1 = {b1.req_rdy, b1.wr, b1.wr_data, owner1, busy1, xfer1};

  int n_chk = 0;
  int n_pass = 0;

  // behavioural model of the MAX_BURST=4 instance
  int m_rr, m_owner, m_bcnt, m_xfer;
  bit m_busy;
  logic [3:0]  e;
  int          g;
  logic [39:0] ev;

  task automatic m_reset();
    m_rr = 0; m_owner = 0; m_bcnt = 0; m_xfer = 0; m_busy = 0;
  endtask

  // who gets the port this cycle (-1 = nobody)
  function automatic int m_pick(logic [3:0] el, logic f);
    int s;
    if (f) return -1;
    if (m_busy && el[m_owner]) return m_owner;
    s = m_busy ? (m_owner + 1) % 4 : m_rr;
    for (int k = 0; k < 4; k++)
      if (el[(s + k) % 4]) return (s + k) % 4;
    return -1;
  endfunction

  task automatic m_commit(int gi, logic [3:0] el);
    if (m_busy && !el[m_owner]) begin
      m_busy = 0;
      m_rr = (m_owner + 1) % 4;
    end
    if (gi >= 0) begin
      m_xfer = (m_xfer + 1) % 65536;
      if (m_busy) begin
        m_bcnt++;
        if (m_bcnt == 4) begin m_busy = 0; m_rr = (m_owner + 1) % 4; end
      end else begin
        m_owner = gi; m_bcnt = 1; m_busy = 1;
      end
    end
  endtask

  function automatic logic [39:0] m_expect(int gi);
    logic [3:0]  r;
    logic [15:0] d;
    logic [63:0] all;
    all = a0.req_data;
    r = (gi >= 0) ? 4'(1 << gi) : 4'b0;
    d = (gi >= 0) ? all[gi*16 +: 16] : 16'h0;
    return {r, (gi >= 0), d, 2'(m_owner), m_busy, 16'(m_xfer)};
  endfunction

  task automatic apply_reset();
    a0.req_vld = '0; a0.req_en_mask = 4'hf; a0.full = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    m_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    a0.req_vld = 4'hf; a0.req_en_mask = 4'hf; a0.full = 1'b0;
    a0.req_data = {$urandom, $urandom};
    #2;
    n_chk++;
    if (act0 !== 40'h0) $display("FAIL reset_initial got=%h want=%h", act0, 40'h0);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    m_reset();
    a0.req_vld = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      a0.req_data = {$urandom, $urandom};
      #3; e = a0.req_vld & a0.req_en_mask; g = m_pick(e, a0.full); ev = m_expect(g);
      n_chk++;
      if (act0 !== ev) $display("FAIL reset_pre cyc=%0d got=%h want=%h", c, act0, ev);
      else n_pass++;
      m_commit(g, e); @(posedge clk); #1;
    end
    // owner=2, two words into its burst: reset lands mid-cycle
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (act0 !== 40'h0) $display("FAIL reset_midburst got=%h want=%h", act0, 40'h0);
    else n_pass++;
    m_reset();
    @(posedge clk); #1 rst = 1'b0;
    a0.req_vld = 4'b1010;
    #3;
    n_chk++;
    if (a0.req_rdy !== 4'b0010) $display("FAIL reset_first_grant got=%b want=%b", a0.req_rdy, 4'b0010);
    else n_pass++;
    e = a0.req_vld & a0.req_en_mask; g = m_pick(e, a0.full); ev = m_expect(g);
    n_chk++;
    if (act0 !== ev) $display("FAIL reset_post got=%h want=%h", act0, ev);
    else n_pass++;
    m_commit(g, e); @(posedge clk); #1;
  endtask

  task automatic test_rotation();
    apply_reset();
    a0.req_vld = 4'hf; a0.req_en_mask = 4'hf;
    for (int c = 0; c < 16; c++) begin
      a0.req_data = {$urandom, $urandom};
      #3; e = a0.req_vld & a0.req_en_mask; g = m_pick(e, a0.full); ev = m_expect(g);
      n_chk++;
      if (a0.req_rdy !== 4'(1 << (c / 4)) || a0.wr !== 1'b1)
        $display("FAIL rotation_order cyc=%0d got=%b want=%b", c, a0.req_rdy, 4'(1 << (c / 4)));
      else n_pass++;
      n_chk++;
      if (act0 !== ev) $display("FAIL rotation cyc=%0d got=%h want=%h", c, act0, ev);
      else n_pass++;
      m_commit(g, e); @(posedge clk); #1;
    end
    a0.req_vld = '0;
    n_chk++;
    if (xfer0 !== 16'd16) $display("FAIL rotation_count got=%0d want=16", xfer0);
    else n_pass++;
  endtask

  task automatic test_stall();
    int tbl[8] = '{1, 1, -1, -1, -1, 1, 1, 2};
    apply_reset();
    a0.req_vld = 4'b0110; a0.req_en_mask = 4'hf;
    for (int c = 0; c < 8; c++) begin
      a0.full = (c >= 2 && c <= 4);
      a0.req_data = {$urandom, $urandom};
      #3; e = a0.req_vld & a0.req_en_mask; g = m_pick(e, a0.full); ev = m_expect(g);
      n_chk++;
      if (a0.req_rdy !== ((tbl[c] >= 0) ? 4'(1 << tbl[c]) : 4'b0))
        $display("FAIL stall_grant cyc=%0d got=%b want_idx=%0d", c, a0.req_rdy, tbl[c]);
      else n_pass++;
      if (a0.full) begin
        n_chk++;
        if (owner0 !== 2'd1 || busy0 !== 1'b1 || a0.wr !== 1'b0)
          $display("FAIL stall_hold cyc=%0d got owner=%0d busy=%b wr=%b want 1 1 0", c, owner0, busy0, a0.wr);
        else n_pass++;
      end
      n_chk++;
      if (act0 !== ev) $display("FAIL stall cyc=%0d got=%h want=%h", c, act0, ev);
      else n_pass++;
      m_commit(g, e); @(posedge clk); #1;
    end
    a0.full = 1'b0;
  endtask

  task automatic test_release();
    int tbl[4] = '{0, 0, 2, 2};
    apply_reset();
    a0.req_en_mask = 4'hf;
    for (int c = 0; c < 4; c++) begin
      a0.req_vld = (c < 2) ? 4'b1101 : 4'b1100;
      a0.req_data = {$urandom, $urandom};
      #3; e = a0.req_vld & a0.req_en_mask; g = m_pick(e, a0.full); ev = m_expect(g);
      n_chk++;
      if (a0.req_rdy !== 4'(1 << tbl[c]))
        $display("FAIL release_grant cyc=%0d got=%b want=%b", c, a0.req_rdy, 4'(1 << tbl[c]));
      else n_pass++;
      n_chk++;
      if (act0 !== ev) $display("FAIL release cyc=%0d got=%h want=%h", c, act0, ev);
      else n_pass++;
      m_commit(g, e); @(posedge clk); #1;
    end
  endtask

  task automatic test_mask();
    logic [3:0] w;
    apply_reset();
    a0.req_vld = 4'hf; a0.req_en_mask = 4'b1010;
    for (int c = 0; c < 16; c++) begin
      w = ((c / 4) % 2 == 0) ? 4'b0010 : 4'b1000;
      a0.req_data = {$urandom, $urandom};
      #3; e = a0.req_vld & a0.req_en_mask; g = m_pick(e, a0.full); ev = m_expect(g);
      n_chk++;
      if (a0.req_rdy !== w) $display("FAIL mask_grant cyc=%0d got=%b want=%b", c, a0.req_rdy, w);
      else n_pass++;
      n_chk++;
      if (act0 !== ev) $display("FAIL mask cyc=%0d got=%h want=%h", c, act0, ev);
      else n_pass++;
      m_commit(g, e); @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      a0.req_vld = 4'($urandom | $urandom);
      if (c % 8 == 0) a0.req_en_mask = 4'($urandom);
      a0.full = ($urandom_range(0, 3) == 0);
      a0.req_data = {$urandom, $urandom};
      #3; e = a0.req_vld & a0.req_en_mask; g = m_pick(e, a0.full); ev = m_expect(g);
      n_chk++;
      if (act0 !== ev) $display("FAIL random cyc=%0d got=%h want=%h", c, act0, ev);
      else n_pass++;
      m_commit(g, e); @(posedge clk); #1;
    end
    a0.req_vld = '0; a0.full = 1'b0;
  endtask

  // pure round-robin instance: next grant is the first eligible after the last one
  task automatic test_burst1();
    int last, nxt, own;
    logic [63:0] d;
    logic [27:0] w;
    apply_reset();
    last = 3; own = 0;
    b1.req_vld = 4'b1001; b1.req_en_mask = 4'hf; b1.full = 1'b0;
    for (int k = 0; k < 20; k++) begin
      d = {$urandom, $urandom};
      b1.req_data = d;
      #3;
      nxt = -1;
      for (int j = 1; j <= 4; j++)
        if (nxt < 0 && b1.req_vld[(last + j) % 4]) nxt = (last + j) % 4;
      w = {4'(1 << nxt), 1'b1, d[nxt*16 +: 16], 2'(own), 1'b0, 4'(k % 16)};
      n_chk++;
      if (act1 !== w) $display("FAIL burst1 cyc=%0d got=%h want=%h", k, act1, w);
      else n_pass++;
      if (k == 16) begin
        n_chk++;
        if (xfer1 !== 4'd0) $display("FAIL burst1_wrap got=%0d want=0", xfer1);
        else n_pass++;
      end
      last = nxt; own = nxt;
      @(posedge clk); #1;
    end
    b1.req_vld = '0;
  endtask

  initial begin
    b1.req_vld = '0; b1.req_en_mask = '0; b1.full = 1'b0; b1.req_data = '0;
    a0.req_vld = '0; a0.req_en_mask = '0; a0.full = 1'b0; a0.req_data = '0;
    m_reset();
    test_reset();
    test_rotation();
    test_stall();
    test_release();
    test_mask();
    test_random();
    test_burst1();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the single write port of the 16-bit sync FIFO (wr / wr_data / full) between N_REQ producers. Uses round-robin arbitration with bounded burst ownership, so one producer can write up to MAX_BURST consecutive words before priority rotates. Sits directly in front of the FIFO's DUT-side write inputs. Keeps a running count of accepted words for the bench and debug.

Parameters:
N_REQ, 4, number of requesters (>=2)
DATA_W, 16, word width; must match FIFO wr_data width
MAX_BURST, 4, max consecutive words per ownership (>=1; 1 = pure round-robin)
CNT_W, 16, width of xfer_cnt

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous active-high reset
req_vld  input  N_REQ  requester i has a word on its data slice
req_data  input  N_REQ*DATA_W  flattened data; slice i = bits [i*DATA_W +: DATA_W]
req_en_mask  input  N_REQ  1 = requester i eligible; 0 = ignored
req_rdy  output  N_REQ  combinational one-hot accept; word i transfers at posedge when req_vld[i]&req_rdy[i]
wr  output  1  FIFO write strobe
wr_data  output  DATA_W  FIFO write data
full  input  1  FIFO full flag
owner  output  clog2(N_REQ)  registered index of current burst owner
busy  output  1  1 while in state BURST
xfer_cnt  output  CNT_W  total words written, wraps modulo 2^CNT_W

Behaviour:
- eligible[i] = req_vld[i] & req_en_mask[i].
- Registered state: fsm {IDLE, BURST}, rr_ptr, owner, burst_cnt, xfer_cnt.
- Reset (async, any time, including mid-burst): fsm=IDLE, rr_ptr=0, owner=0, burst_cnt=0, xfer_cnt=0. req_rdy=0 and wr=0 while rst=1 (combinational gating). busy=0. In-flight burst is abandoned; no partial word is written.
- Selection in IDLE: first eligible index scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
- IDLE, full=0, any eligible:
  - grant sel: req_rdy[sel]=1, wr=1, wr_data=slice sel.
  - owner<=sel, burst_cnt<=1.
  - If MAX_BURST==1: stay IDLE, rr_ptr<=sel+1. Else go to BURST.
- IDLE, full=1 or no eligible: no grant, state and rr_ptr unchanged.
- BURST, eligible[owner]=1, full=0:
  - grant owner, burst_cnt<=burst_cnt+1.
  - If burst_cnt+1==MAX_BURST: go to IDLE, rr_ptr<=owner+1.
- BURST, eligible[owner]=1, full=1: stall. No grant, ownership and burst_cnt held.
- BURST, eligible[owner]=0 (vld dropped or masked): release in the same cycle. Treat as IDLE with rr_ptr=owner+1; a new grant may issue that cycle (no bubble). rr_ptr<=owner+1 in all cases.
- wr = |req_rdy; wr_data = selected slice when wr=1, else 0.
- At most one req_rdy bit high. wr never high while full=1. Latency from request to accept is 0 cycles (combinational).
- xfer_cnt increments by 1 on each posedge with wr=1; wraps from all-ones to 0.
- Index wrap: owner+1 where owner=N_REQ-1 gives 0.
- req_vld may drop without acceptance; no protocol error.

Test Plan:
- Reset: assert rst mid-burst (owner=2, burst_cnt=2) -> req_rdy=0 and wr=0 immediately; after release owner=0, xfer_cnt=0, busy=0, first grant goes to the lowest eligible index.
- All 4 requesters vld, mask=4'b1111, full=0, MAX_BURST=4 -> wr high for 16 consecutive cycles; grant order is 4×req0, 4×req1, 4×req2, 4×req3; xfer_cnt=16.
- req1 owns, full=1 for 3 cycles after its 2nd word -> wr=0, req_rdy=0, owner=1, busy=1 during stall; then 2 more req1 words, then req2 granted.
- req0 owns and drops vld after 2 words while req2 vld -> req_rdy[2]=1 in that same cycle, no idle cycle; rr_ptr=1 before selection, so req2 wins over req3.
- mask=4'b1010, all vld -> only req1 and req3 are granted, in alternating 4-word bursts; req_rdy[0] and req_rdy[2] never assert.
- MAX_BURST=1, req0 and req3 vld continuously -> grants alternate req0, req3, req0, ...; busy stays 0; xfer_cnt with CNT_W=4 wraps from 15 to 0 on the 16th write.
